// File: rtl/rwc_irq_bank.sv
// Bank of NUM read/write-clear status registers with per-register interrupt mask,
// saturating overrun counters and an aggregated (level or pulse) interrupt.
module rwc_irq_bank #(
   parameter int unsigned     DW                   = 8,
   parameter int unsigned     AW                   = 8,
   parameter int unsigned     NUM                  = 4,
   parameter logic [AW-1:0]   BASE_ADDR            = '0,
   parameter logic [DW-1:0]   DEFAULT_VAL          = '0,
   parameter logic [DW-1:0]   MASK_DEFAULT         = '1,
   parameter logic            EDGE_MODE            = 1'b0,
   parameter logic            IRQ_PULSE            = 1'b0,
   parameter int unsigned     CNT_W                = 4,
   parameter logic            SUPPORT_TEST_MODE_WR = 1'b1,
   parameter logic            SUPPORT_TEST_MODE_RD = 1'b1,
   parameter logic            SUPPORT_CFG_MODE_WR  = 1'b1,
   parameter logic            SUPPORT_CFG_MODE_RD  = 1'b1
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_wen,
   input  logic                i_ren,
   input  logic                i_test_mode_status,
   input  logic                i_cfg_mode_status,
   input  logic [AW-1:0]       i_addr,
   input  logic [DW-1:0]       i_wdata,
   output logic [DW-1:0]       o_rdata,
   input  logic [NUM*DW-1:0]   i_lgc_set,
   output logic [NUM*DW-1:0]   o_reg_data,
   output logic [NUM-1:0]      o_irq_vec,
   output logic                o_irq
);

   logic [DW-1:0]     status_q [NUM];
   logic [DW-1:0]     status_d [NUM];
   logic [DW-1:0]     mask_q   [NUM];
   logic [DW-1:0]     mask_d   [NUM];
   logic [CNT_W-1:0]  cnt_q    [NUM];
   logic [CNT_W-1:0]  cnt_d    [NUM];
   logic [NUM*DW-1:0] src_d_q;
   logic [NUM*DW-1:0] set_ev;
   logic [NUM-1:0]    st_sel, mk_sel, ct_sel;
   logic [NUM-1:0]    pending;
   logic              wr_ok, rd_ok;
   logic              irq_lvl, irq_lvl_d_q;

   assign wr_ok = i_wen & ((i_test_mode_status & SUPPORT_TEST_MODE_WR) |
                           (i_cfg_mode_status  & SUPPORT_CFG_MODE_WR));
   assign rd_ok = i_ren & ((i_test_mode_status & SUPPORT_TEST_MODE_RD) |
                           (i_cfg_mode_status  & SUPPORT_CFG_MODE_RD));

   assign set_ev = EDGE_MODE ? (i_lgc_set & ~src_d_q) : i_lgc_set;

   always_comb begin
      st_sel = '0;
      mk_sel = '0;
      ct_sel = '0;
      for (int unsigned k = 0; k < NUM; k++) begin
         st_sel[k] = (i_addr == AW'(BASE_ADDR + k));
         mk_sel[k] = (i_addr == AW'(BASE_ADDR + NUM + k));
         ct_sel[k] = (i_addr == AW'(BASE_ADDR + 2*NUM + k));
      end
   end

   // Set beats CPU clear; overrun looks at the pre-cycle status value.
   always_comb begin
      for (int unsigned k = 0; k < NUM; k++) begin
         status_d[k] = set_ev[k*DW +: DW] |
                       (status_q[k] & ~((wr_ok & st_sel[k]) ? i_wdata : '0));
         mask_d[k]   = (wr_ok & mk_sel[k]) ? i_wdata : mask_q[k];
         cnt_d[k]    = cnt_q[k];
         if (wr_ok & ct_sel[k])
            cnt_d[k] = '0;
         else if ((|(set_ev[k*DW +: DW] & status_q[k])) && (cnt_q[k] != '1))
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned k = 0; k < NUM; k++) begin
            status_q[k] <= DEFAULT_VAL;
            mask_q[k]   <= MASK_DEFAULT;
            cnt_q[k]    <= '0;
         end
         src_d_q     <= '0;
         o_irq_vec   <= '0;
         irq_lvl_d_q <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < NUM; k++) begin
            status_q[k] <= status_d[k];
            mask_q[k]   <= mask_d[k];
            cnt_q[k]    <= cnt_d[k];
         end
         src_d_q     <= i_lgc_set;
         o_irq_vec   <= pending;
         irq_lvl_d_q <= irq_lvl;
      end
   end

   always_comb begin
      o_reg_data = '0;
      pending    = '0;
      for (int unsigned k = 0; k < NUM; k++) begin
         o_reg_data[k*DW +: DW] = status_q[k];
         pending[k]             = |(status_q[k] & ~mask_q[k]);
      end
   end

   assign irq_lvl = |o_irq_vec;
   assign o_irq   = IRQ_PULSE ? (irq_lvl & ~irq_lvl_d_q) : irq_lvl;

   always_comb begin
      o_rdata = '0;
      if (rd_ok) begin
         for (int unsigned k = 0; k < NUM; k++) begin
            if (st_sel[k]) o_rdata = status_q[k];
            if (mk_sel[k]) o_rdata = mask_q[k];
            if (ct_sel[k]) o_rdata = DW'(cnt_q[k]);
         end
      end
   end

endmodule

// File: tb/tb_rwc_irq_bank.sv
// Directed bench for rwc_irq_bank: a level/high-set instance (u_lvl) and an
// edge-capture/pulse-irq instance (u_pls) sharing the bus and source inputs.
module tb_rwc_irq_bank;

   localparam int unsigned DW  = 8;
   localparam int unsigned AW  = 8;
   localparam int unsigned NUM = 4;

   logic        clk = 1'b0;
   logic        rst_n, wen, ren, tmode, cmode;
   logic [7:0]  addr, wdata;
   logic [31:0] lgc_set;
   logic [7:0]  rd_a, rd_b;
   logic [31:0] reg_a, reg_b;
   logic [3:0]  vec_a, vec_b;
   logic        irq_a, irq_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rwc_irq_bank #(.DW(DW), .AW(AW), .NUM(NUM)) u_lvl (
      .i_clk(clk), .i_rst_n(rst_n), .i_wen(wen), .i_ren(ren),
      .i_test_mode_status(tmode), .i_cfg_mode_status(cmode),
      .i_addr(addr), .i_wdata(wdata), .o_rdata(rd_a),
      .i_lgc_set(lgc_set), .o_reg_data(reg_a), .o_irq_vec(vec_a), .o_irq(irq_a)
   );

   rwc_irq_bank #(.DW(DW), .AW(AW), .NUM(NUM), .EDGE_MODE(1'b1), .IRQ_PULSE(1'b1)) u_pls (
      .i_clk(clk), .i_rst_n(rst_n), .i_wen(wen), .i_ren(ren),
      .i_test_mode_status(tmode), .i_cfg_mode_status(cmode),
      .i_addr(addr), .i_wdata(wdata), .o_rdata(rd_b),
      .i_lgc_set(lgc_set), .o_reg_data(reg_b), .o_irq_vec(vec_b), .o_irq(irq_b)
   );

   typedef struct {
      logic        wen;
      logic        ren;
      logic [7:0]  addr;
      logic [7:0]  wdata;
      logic [31:0] set;
      logic [7:0]  e_rd;
      logic [31:0] e_reg;
      logic [3:0]  e_vec;
      logic        e_irq;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic w, input logic r, input logic t, input logic c,
                      input logic [7:0] a, input logic [7:0] d, input logic [31:0] s);
      wen = w; ren = r; tmode = t; cmode = c; addr = a; wdata = d; lgc_set = s;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp8;

      // status vectors: inputs applied, outputs checked before the edge
      tbl[0]  = '{1'b1, 1'b0, 8'h04, 8'hFE, 32'h0,        8'h00, 32'h0,        4'h0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 8'h04, 8'h00, 32'h00000001, 8'hFE, 32'h0,        4'h0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 8'h00, 8'h00, 32'h0,        8'h01, 32'h00000001, 4'h0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 32'h0,        8'h00, 32'h00000001, 4'h1, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 8'h00, 8'h01, 32'h0,        8'h00, 32'h00000001, 4'h1, 1'b1};
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 8'h00, 32'h0,        8'h00, 32'h0,        4'h1, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 32'h0,        8'h00, 32'h0,        4'h0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 32'h00080000, 8'h00, 32'h0,        4'h0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 8'h02, 8'h08, 32'h00080000, 8'h00, 32'h00080000, 4'h0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 8'h0A, 8'h00, 32'h0,        8'h01, 32'h00080000, 4'h0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 8'h02, 8'h00, 32'h0,        8'h08, 32'h00080000, 4'h0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 8'h02, 8'h08, 32'h0,        8'h00, 32'h00080000, 4'h0, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 8'h02, 8'h00, 32'h0,        8'h00, 32'h0,        4'h0, 1'b0};

      rst_n = 1'b0;
      drv(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // reset state: full map plus one unmapped address
      for (int a = 0; a < 13; a++) begin
         drv(1'b0, 1'b1, 1'b0, 1'b1, 8'(a), 8'h00, 32'h0);
         #1;
         exp8 = (a >= 4 && a < 8) ? 8'hFF : 8'h00;
         chk($sformatf("rst_rd[%0d]", a), 32'(rd_a), 32'(exp8));
         step();
      end
      chk("rst_irq_a", 32'(irq_a), 32'h0);
      chk("rst_vec_a", 32'(vec_a), 32'h0);
      chk("rst_irq_b", 32'(irq_b), 32'h0);

      for (int i = 0; i < 13; i++) begin
         drv(tbl[i].wen, tbl[i].ren, 1'b0, 1'b1, tbl[i].addr, tbl[i].wdata, tbl[i].set);
         #1;
         chk($sformatf("v%0d_rdata", i), 32'(rd_a), 32'(tbl[i].e_rd));
         chk($sformatf("v%0d_reg", i), reg_a, tbl[i].e_reg);
         chk($sformatf("v%0d_vec", i), 32'(vec_a), 32'(tbl[i].e_vec));
         chk($sformatf("v%0d_irq", i), 32'(irq_a), 32'(tbl[i].e_irq));
         step();
      end

      // reg1 bit0 held: 1 set + 20 overruns -> saturates at 15
      for (int i = 0; i < 21; i++) begin
         drv(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 32'h00000100);
         step();
      end
      drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h09, 8'h00, 32'h00000100);
      #1 chk("cnt1_sat", 32'(rd_a), 32'h0F);
      step();
      // clear via test mode while an overrun is still occurring: overrun dropped
      drv(1'b1, 1'b0, 1'b1, 1'b0, 8'h09, 8'h5A, 32'h00000100);
      step();
      drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h09, 8'h00, 32'h0);
      #1 chk("cnt1_clr", 32'(rd_a), 32'h00);
      step();
      drv(1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 32'h0);
      step();
      drv(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 32'h0);
      #1 chk("gated_rd", 32'(rd_a), 32'h00);
      step();
      drv(1'b0, 1'b1, 1'b1, 1'b0, 8'h05, 8'h00, 32'h0);
      #1 chk("mask1_kept", 32'(rd_a), 32'hFF);
      step();
      drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 32'h0);
      #1 chk("status1", 32'(rd_a), 32'h01);
      step();

      // pending on unmasked reg0, then reset mid-operation
      drv(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 32'h00000001);
      step();
      drv(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 32'h0);
      step();
      #1;
      chk("pre_rst_vec", 32'(vec_a), 32'h1);
      chk("pre_rst_irq", 32'(irq_a), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_reg", reg_a, 32'h0);
      chk("mid_rst_vec", 32'(vec_a), 32'h0);
      chk("mid_rst_irq", 32'(irq_a), 32'h0);
      drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 8'h00, 32'h0);
      #1 chk("mid_rst_mask0", 32'(rd_a), 32'hFF);
      step();
      rst_n = 1'b1;
      step();

      // edge capture on u_pls: set once, CPU clear sticks while source stays high
      drv(1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 8'h00, 32'h0);
      step();
      drv(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 32'h00000001);
      step();
      drv(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 32'h00000001);
      #1 chk("edge_set", reg_b, 32'h00000001);
      step();
      for (int i = 0; i < 5; i++) begin
         drv(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 32'h00000001);
         #1 chk($sformatf("edge_hold%0d", i), reg_b, 32'h0);
         step();
      end
      drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h08, 8'h00, 32'h0);
      #1 chk("edge_cnt0", 32'(rd_b), 32'h00);
      step();
      repeat (3) step();

      // pulse irq: two sources 3 cycles apart -> one pulse
      drv(1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 32'h0);
      step();
      for (int i = 0; i < 8; i++) begin
         drv(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00,
             (i == 0) ? 32'h00000001 : (i == 3) ? 32'h00000100 : 32'h0);
         #1 chk($sformatf("pulse1_c%0d", i), 32'(irq_b), (i == 2) ? 32'h1 : 32'h0);
         step();
      end
      chk("pulse1_vec", 32'(vec_b), 32'h3);
      drv(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 32'h0);
      step();
      drv(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 32'h0);
      step();
      for (int i = 0; i < 3; i++) begin
         drv(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 32'h0);
         #1 chk($sformatf("drop_c%0d", i), 32'(irq_b), 32'h0);
         step();
      end
      chk("drop_vec", 32'(vec_b), 32'h0);
      for (int i = 0; i < 5; i++) begin
         drv(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, (i == 0) ? 32'h00000001 : 32'h0);
         #1 chk($sformatf("pulse2_c%0d", i), 32'(irq_b), (i == 2) ? 32'h1 : 32'h0);
         step();
      end

      // reset with aggregate high: no pulse on release
      rst_n = 1'b0;
      #1;
      chk("rst_b_vec", 32'(vec_b), 32'h0);
      chk("rst_b_reg", reg_b, 32'h0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("rel_irq%0d", i), 32'(irq_b), 32'h0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
